bcd2bin_seq: RTL and testbench

BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

---
 rtl/bcd2bin_seq_pkg.sv | 20 ++
 rtl/bcd2bin_seq_sub3.sv | 11 +
 rtl/bcd2bin_seq.sv | 102 ++++++++++
 tb/tb_bcd2bin_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bcd2bin_seq_pkg.sv
// Shared constants and FSM encoding for the BCD/binary converter family.
package bcd2bin_seq_pkg;

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned N_DIGITS = 4;
    localparam int unsigned BIN_W    = 14;
    localparam int unsigned N_STEPS  = BIN_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // A BCD digit is only legal in the range 0..9.
    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd2bin_seq_sub3.sv
// One BCD field correction step of reverse double dabble: subtract 3 when >= 8.
module bcd_digit_sub3
    import bcd2bin_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_d,
    output logic [DIGIT_W-1:0] o_d
);

    assign o_d = (i_d >= 4'd8) ? (i_d - 4'd3) : i_d;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter using reverse double dabble,
// one shift/correct step per clock.
module bcd2bin_seq #(
    parameter int unsigned N_DIGITS = bcd2bin_seq_pkg::N_DIGITS,
    parameter int unsigned BIN_W    = bcd2bin_seq_pkg::BIN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  valid,
    output logic                  err,
    output logic                  busy
);

    import bcd2bin_seq_pkg::*;

    localparam int unsigned BCD_W = 4 * N_DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned STEPS = BIN_W;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    state_t           r_state;
    logic [SR_W-1:0]  r_sr;
    logic [CNT_W-1:0] r_cnt;

    logic [SR_W-1:0]  w_shifted;
    logic [SR_W-1:0]  w_next;
    logic             w_bad;

    // Shift right, then correct every BCD field in the upper part of the register.
    assign w_shifted            = r_sr >> 1;
    assign w_next[BIN_W-1:0]    = w_shifted[BIN_W-1:0];

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        bcd_digit_sub3 u_sub3 (
            .i_d (w_shifted[BIN_W + g*DIGIT_W +: DIGIT_W]),
            .o_d (w_next[BIN_W + g*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_invalid(bcd_in[i*DIGIT_W +: DIGIT_W])) begin
                w_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            bin_out <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (w_bad) begin
                            // Illegal digit: report immediately without converting.
                            bin_out <= '0;
                            err     <= 1'b1;
                            valid   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_sr    <= {bcd_in, {BIN_W{1'b0}}};
                            r_cnt   <= '0;
                            r_state <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    r_sr  <= w_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(STEPS - 1)) begin
                        bin_out <= w_next[BIN_W-1:0];
                        err     <= 1'b0;
                        valid   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed self-checking bench for bcd2bin_seq.
module tb_bcd2bin_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcd_in;
    logic [13:0] bin_out;
    logic        valid;
    logic        err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int exp_prev = 0;

    bcd2bin_seq #(.N_DIGITS(4), .BIN_W(14)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .valid   (valid),
        .err     (err),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference binary-to-BCD conversion.
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    // Issue one conversion from IDLE; lat is the number of edges after the accept edge.
    task automatic run_conv(input logic [15:0] b, input int exp_bin, input logic exp_err,
                            input int exp_lat, input string tag);
        int n;
        start  = 1'b1;
        bcd_in = b;
        @(posedge clk); #1;
        start  = 1'b0;
        bcd_in = 16'h8765;
        n = 0;
        while (!valid && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 5 && !valid) check({tag, "_hold"}, int'(bin_out), exp_prev);
        end
        if (!valid) check({tag, "_timeout"}, 0, 1);
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_bin"}, int'(bin_out), exp_bin);
        check({tag, "_err"}, int'(err), int'(exp_err));
        @(posedge clk); #1;
        check({tag, "_vdrop"}, int'(valid), 0);
        check({tag, "_idle"}, int'(busy), 0);
        exp_prev = exp_bin;
    endtask

    initial begin
        int pulses;
        int first_at;
        int second_at;
        int got_bin;

        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bin", int'(bin_out), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_conv(16'h9999, 9999, 1'b0, 14, "max");
        run_conv(16'h1234, 1234, 1'b0, 14, "v1234");
        run_conv(16'h0000, 0,    1'b0, 14, "zero");
        run_conv(16'h0001, 1,    1'b0, 14, "one");
        run_conv(16'h12A4, 0,    1'b1, 0,  "bad");
        run_conv(16'h0042, 42,   1'b0, 14, "v42");
        run_conv(16'hF000, 0,    1'b1, 0,  "badtop");

        // Start and new data during CONV must be ignored.
        start  = 1'b1;
        bcd_in = 16'h0815;
        @(posedge clk); #1;
        start  = 1'b0;
        pulses = 0;
        got_bin = 0;
        for (int i = 1; i <= 24; i++) begin
            if (i == 3) begin start = 1'b1; bcd_in = 16'h5555; end
            if (i == 10) start = 1'b0;
            @(posedge clk); #1;
            if (valid) begin pulses++; got_bin = int'(bin_out); end
        end
        check("ign_pulses", pulses, 1);
        check("ign_bin", got_bin, 815);
        exp_prev = 815;

        // Async reset in the middle of a conversion.
        start  = 1'b1;
        bcd_in = 16'h0777;
        @(posedge clk); #1;
        start  = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("arst_bin", int'(bin_out), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_err", int'(err), 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (valid) pulses++;
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (valid) pulses++;
        end
        check("arst_nopulse", pulses, 0);
        exp_prev = 0;
        run_conv(16'h0512, 512, 1'b0, 14, "after_rst");

        // start held high: accept, 14 steps, DONE, one IDLE cycle, accept again.
        start  = 1'b1;
        bcd_in = 16'h0007;
        first_at  = -1;
        second_at = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                if (first_at < 0) first_at = i;
                else if (second_at < 0) second_at = i;
            end
        end
        start = 1'b0;
        check("b2b_first", first_at, 15);
        check("b2b_gap", second_at - first_at, 16);
        check("b2b_bin", int'(bin_out), 7);
        repeat (20) @(posedge clk);
        #1;
        exp_prev = 7;

        // Round trip over a strided range plus the edges of the input space.
        for (int v = 0; v <= 9999; v += 37) begin
            run_conv(to_bcd(v), v, 1'b0, 14, "sweep");
        end
        run_conv(to_bcd(9998), 9998, 1'b0, 14, "sweep_9998");
        run_conv(to_bcd(8000), 8000, 1'b0, 14, "sweep_8000");
        run_conv(to_bcd(1009), 1009, 1'b0, 14, "sweep_1009");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
